downsampler_stream: RTL and testbench

- Parametrised 2^L x 2^L spatial downsampler for the camera pixel stream, with a built-in synchronous output FIFO and ready/valid backpressure.
- Replaces the downsampler-plus-FIFO pair on single-clock paths.
- Adds selectable decimate or box-average mode, configurable frame geometry, and end-of-line/end-of-frame tags.
- Sits between the pixel capture front end and the feature-detection pipeline.

---
 rtl/downsampler_stream.sv | 184 ++++++++++++++++++
 tb/tb_downsampler_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/downsampler_stream.sv
// 2^L x 2^L spatial downsampler (decimate or box-average) for the camera pixel
// stream, with a first-word-fall-through output FIFO and ready/valid backpressure.
module downsampler_stream #(
    parameter int DATA_W      = 8,
    parameter int LINE_W      = 640,
    parameter int FRAME_H     = 480,
    parameter int FACTOR_LOG2 = 1,
    parameter int MODE        = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic                         sof_in,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         eol_out,
    output logic                         eof_out,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int F      = 1 << FACTOR_LOG2;
    localparam int OXN    = LINE_W / F;
    localparam int OYN    = FRAME_H / F;
    localparam int COL_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int OX_W   = (OXN > 1) ? $clog2(OXN) : 1;
    localparam int OY_W   = (OYN > 1) ? $clog2(OYN) : 1;
    localparam int SUM_W  = DATA_W + 2 * FACTOR_LOG2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = DATA_W + 2;

    logic [COL_W-1:0]       col, col_e;
    logic [ROW_W-1:0]       row, row_e;
    logic [FACTOR_LOG2-1:0] cx, ry;
    logic [OX_W-1:0]        ox;
    logic [OY_W-1:0]        oy;
    logic                   cx_first, cx_last, ry_first, ry_last;
    logic                   eol_c, eof_c;
    logic [SUM_W-1:0]       hsum, hsum_next;

    logic                   s1_valid, s1_first, s1_last, s1_eol, s1_eof;
    logic [SUM_W-1:0]       s1_val;
    logic [OX_W-1:0]        s1_ox;
    logic [SUM_W-1:0]       total;
    logic [SUM_W-1:0]       line_mem [0:OXN-1];

    logic                   s2_valid;
    logic [WORD_W-1:0]      s2_word;

    logic [WORD_W-1:0]      fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [WORD_W-1:0]      head;
    logic                   push, pop, full, accept;

    // An accepted sof relocates this beat to (0,0), abandoning any partial block.
    always_comb begin
        col_e     = (valid_in && sof_in) ? '0 : col;
        row_e     = (valid_in && sof_in) ? '0 : row;
        cx        = col_e[FACTOR_LOG2-1:0];
        ry        = row_e[FACTOR_LOG2-1:0];
        ox        = OX_W'(col_e >> FACTOR_LOG2);
        oy        = OY_W'(row_e >> FACTOR_LOG2);
        cx_first  = (cx == '0);
        cx_last   = &cx;
        ry_first  = (ry == '0);
        ry_last   = &ry;
        eol_c     = (ox == OX_W'(OXN - 1));
        eof_c     = eol_c && (oy == OY_W'(OYN - 1));
        hsum_next = (cx_first ? '0 : hsum) + SUM_W'(data_in);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_e == COL_W'(LINE_W - 1)) begin
                col <= '0;
                row <= (row_e == ROW_W'(FRAME_H - 1)) ? '0 : row_e + ROW_W'(1);
            end else begin
                col <= col_e + COL_W'(1);
                row <= row_e;
            end
        end
    end

    // Decimate mode forwards the block's top-left pixel pre-shifted so the
    // common >>2L extraction at stage 2 returns it unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in && ((MODE == 0) ? (cx_first && ry_first) : cx_last);
        end
    end

    always_ff @(posedge clock) begin
        if (valid_in) begin
            hsum     <= hsum_next;
            s1_val   <= (MODE == 0) ? {data_in, {(2 * FACTOR_LOG2){1'b0}}} : hsum_next;
            s1_ox    <= ox;
            s1_first <= ry_first;
            s1_last  <= (MODE == 0) ? 1'b1 : ry_last;
            s1_eol   <= eol_c;
            s1_eof   <= eof_c;
        end
    end

    assign total = s1_first ? s1_val : (line_mem[s1_ox] + s1_val);

    always_ff @(posedge clock) begin
        if (s1_valid) begin
            line_mem[s1_ox] <= total;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid && s1_last;
        end
    end

    always_ff @(posedge clock) begin
        if (s1_valid) begin
            s2_word <= {s1_eof, s1_eol, total[SUM_W-1:2*FACTOR_LOG2]};
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    always_comb begin
        push   = s2_valid;
        pop    = valid_out && ready_out;
        full   = (fifo_count == CNT_W'(FIFO_DEPTH));
        accept = push && (!full || pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end else if (valid_in && sof_in) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= s2_word;
        end
    end

    always_comb begin
        head      = fifo_mem[rd_ptr];
        valid_out = (fifo_count != '0);
        data_out  = valid_out ? head[DATA_W-1:0] : '0;
        eol_out   = valid_out && head[DATA_W];
        eof_out   = valid_out && head[DATA_W+1];
    end

endmodule

// File: tb/tb_downsampler_stream.sv
// Directed self-checking bench: 8x4 frames at factor 2, one decimating and one
// box-averaging instance sharing the same input stream, both with a 4-deep FIFO.
module tb_downsampler_stream;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0;
    logic       sof_in = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       ready_out = 1'b0;

    logic [7:0] m0_data_out, m1_data_out;
    logic       m0_valid_out, m1_valid_out;
    logic       m0_eol_out, m1_eol_out, m0_eof_out, m1_eof_out;
    logic       m0_overflow, m1_overflow;
    logic [2:0] m0_fifo_count, m1_fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pix0_cyc = 0;
    int first_valid_cyc = -1;
    bit seen0 = 1'b0;
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    downsampler_stream #(.DATA_W(8), .LINE_W(8), .FRAME_H(4), .FACTOR_LOG2(1),
                         .MODE(0), .FIFO_DEPTH(4)) u_m0 (
        .clock(clock), .reset(reset), .valid_in(valid_in), .sof_in(sof_in),
        .data_in(data_in), .data_out(m0_data_out), .valid_out(m0_valid_out),
        .ready_out(ready_out), .eol_out(m0_eol_out), .eof_out(m0_eof_out),
        .overflow(m0_overflow), .fifo_count(m0_fifo_count));

    downsampler_stream #(.DATA_W(8), .LINE_W(8), .FRAME_H(4), .FACTOR_LOG2(1),
                         .MODE(1), .FIFO_DEPTH(4)) u_m1 (
        .clock(clock), .reset(reset), .valid_in(valid_in), .sof_in(sof_in),
        .data_in(data_in), .data_out(m1_data_out), .valid_out(m1_valid_out),
        .ready_out(ready_out), .eol_out(m1_eol_out), .eof_out(m1_eof_out),
        .overflow(m1_overflow), .fifo_count(m1_fifo_count));

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Popped words are recorded as {eof, eol, data} mid-cycle, when ready/valid are stable.
    initial forever begin
        @(negedge clock);
        if (m0_valid_out && !seen0) begin
            seen0 = 1'b1;
            first_valid_cyc = cyc;
        end
        if (m0_valid_out && ready_out) q0.push_back({m0_eof_out, m0_eol_out, m0_data_out});
        if (m1_valid_out && ready_out) q1.push_back({m1_eof_out, m1_eol_out, m1_data_out});
    end

    function automatic logic [9:0] w(input int d, input bit eol, input bit eof);
        return {eof, eol, 8'(d)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        sof_in   = 1'b0;
        reset    = 1'b0;
        idle(2);
        reset    = 1'b1;
        idle(1);
    endtask

    // Pixel value is its raster index row*8+col, so start is the first pixel's index.
    task automatic send_pixels(input int start, input int count, input bit sof_first);
        for (int i = 0; i < count; i++) begin
            @(posedge clock);
            #1;
            valid_in = 1'b1;
            sof_in   = sof_first && (i == 0);
            data_in  = 8'(start + i);
            if (i == 0) pix0_cyc = cyc;
        end
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_checks++;
        if ({m0_valid_out, m0_data_out, m0_eol_out, m0_eof_out, m0_overflow, m0_fifo_count} !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_m0: got vld=%b data=%0d eol=%b eof=%b ovf=%b cnt=%0d, expected all 0",
                     m0_valid_out, m0_data_out, m0_eol_out, m0_eof_out, m0_overflow, m0_fifo_count);
        end
        n_checks++;
        if ({m1_valid_out, m1_data_out, m1_eol_out, m1_eof_out, m1_overflow, m1_fifo_count} !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_m1: got vld=%b data=%0d eol=%b eof=%b ovf=%b cnt=%0d, expected all 0",
                     m1_valid_out, m1_data_out, m1_eol_out, m1_eof_out, m1_overflow, m1_fifo_count);
        end
        do_reset();
    endtask

    task automatic test_decimate();
        logic [9:0] exp_q [8];
        exp_q = '{w(0,0,0), w(2,0,0), w(4,0,0), w(6,1,0),
                  w(16,0,0), w(18,0,0), w(20,0,0), w(22,1,1)};
        do_reset();
        ready_out = 1'b1;
        seen0 = 1'b0;
        q0.delete();
        send_pixels(0, 32, 1'b1);
        idle(6);
        n_checks++;
        if (first_valid_cyc - pix0_cyc !== 3) begin
            n_fail++;
            $display("[TB] FAIL dec_latency: got %0d cycles, expected 3", first_valid_cyc - pix0_cyc);
        end
        n_checks++;
        if (q0.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL dec_count: got %0d words, expected 8", q0.size());
        end
        for (int i = 0; i < 8 && i < q0.size(); i++) begin
            n_checks++;
            if (q0[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL dec_word%0d: got %h, expected %h", i, q0[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_box_average();
        logic [9:0] exp_q [8];
        exp_q = '{w(4,0,0), w(6,0,0), w(8,0,0), w(10,1,0),
                  w(20,0,0), w(22,0,0), w(24,0,0), w(26,1,1)};
        do_reset();
        ready_out = 1'b1;
        q1.delete();
        send_pixels(0, 32, 1'b1);
        idle(6);
        n_checks++;
        if (q1.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL avg_count: got %0d words, expected 8", q1.size());
        end
        for (int i = 0; i < 8 && i < q1.size(); i++) begin
            n_checks++;
            if (q1[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL avg_word%0d: got %h, expected %h", i, q1[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q [4];
        exp_q = '{w(0,0,0), w(2,0,0), w(4,0,0), w(6,1,0)};
        do_reset();
        ready_out = 1'b0;
        q0.delete();
        send_pixels(0, 32, 1'b1);
        idle(4);
        n_checks++;
        if (m0_fifo_count !== 3'd4 || m0_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_full: got cnt=%0d ovf=%b, expected cnt=4 ovf=1", m0_fifo_count, m0_overflow);
        end
        ready_out = 1'b1;
        idle(8);
        ready_out = 1'b0;
        n_checks++;
        if (q0.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL ovf_drain_count: got %0d words, expected 4", q0.size());
        end
        for (int i = 0; i < 4 && i < q0.size(); i++) begin
            n_checks++;
            if (q0[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL ovf_word%0d: got %h, expected %h", i, q0[i], exp_q[i]);
            end
        end
        n_checks++;
        if (m0_valid_out !== 1'b0 || m0_fifo_count !== 3'd0 || m0_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_after: got vld=%b cnt=%0d ovf=%b, expected vld=0 cnt=0 ovf=1",
                     m0_valid_out, m0_fifo_count, m0_overflow);
        end
    endtask

    // Word 16 reaches the full FIFO exactly in the one cycle ready_out is high.
    task automatic test_full_push_pop();
        logic [9:0] exp_q [5];
        exp_q = '{w(0,0,0), w(2,0,0), w(4,0,0), w(6,1,0), w(16,0,0)};
        do_reset();
        ready_out = 1'b0;
        q0.delete();
        for (int i = 0; i < 21; i++) begin
            @(posedge clock);
            #1;
            valid_in  = (i <= 16);
            sof_in    = (i == 0);
            data_in   = 8'(i);
            ready_out = (i == 18);
            if (i == 18) begin
                n_checks++;
                if (m0_fifo_count !== 3'd4) begin
                    n_fail++;
                    $display("[TB] FAIL pp_before: got cnt=%0d, expected 4", m0_fifo_count);
                end
            end
        end
        n_checks++;
        if (m0_fifo_count !== 3'd4 || m0_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pp_after: got cnt=%0d ovf=%b, expected cnt=4 ovf=0", m0_fifo_count, m0_overflow);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        idle(8);
        n_checks++;
        if (q0.size() !== 5) begin
            n_fail++;
            $display("[TB] FAIL pp_count: got %0d words, expected 5", q0.size());
        end
        for (int i = 0; i < 5 && i < q0.size(); i++) begin
            n_checks++;
            if (q0[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL pp_word%0d: got %h, expected %h", i, q0[i], exp_q[i]);
            end
        end
    endtask

    // The aborted frame still completes blocks 0 and 1 (values 4 and 6) before the
    // mid-line sof; the block straddling cols 4-5 of rows 0-1 produces nothing.
    task automatic test_sof_restart();
        logic [9:0] exp_q [10];
        exp_q = '{w(4,0,0), w(6,0,0),
                  w(4,0,0), w(6,0,0), w(8,0,0), w(10,1,0),
                  w(20,0,0), w(22,0,0), w(24,0,0), w(26,1,1)};
        do_reset();
        ready_out = 1'b0;
        send_pixels(0, 32, 1'b1);
        idle(4);
        ready_out = 1'b1;
        idle(8);
        q1.delete();
        send_pixels(0, 13, 1'b0);
        n_checks++;
        if (m1_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sof_ovf_pre: got ovf=%b, expected 1", m1_overflow);
        end
        send_pixels(0, 32, 1'b1);
        idle(6);
        n_checks++;
        if (m1_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sof_ovf_clr: got ovf=%b, expected 0", m1_overflow);
        end
        n_checks++;
        if (q1.size() !== 10) begin
            n_fail++;
            $display("[TB] FAIL sof_count: got %0d words, expected 10", q1.size());
        end
        for (int i = 0; i < 10 && i < q1.size(); i++) begin
            n_checks++;
            if (q1[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL sof_word%0d: got %h, expected %h", i, q1[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp_q [8];
        exp_q = '{w(0,0,0), w(2,0,0), w(4,0,0), w(6,1,0),
                  w(16,0,0), w(18,0,0), w(20,0,0), w(22,1,1)};
        do_reset();
        ready_out = 1'b0;
        send_pixels(0, 17, 1'b1);
        idle(4);
        ready_out = 1'b1;
        idle(1);
        ready_out = 1'b0;
        n_checks++;
        if (m0_fifo_count !== 3'd3 || m0_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ar_pre: got cnt=%0d ovf=%b, expected cnt=3 ovf=1", m0_fifo_count, m0_overflow);
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (m0_valid_out !== 1'b0 || m0_fifo_count !== 3'd0 || m0_overflow !== 1'b0 || m0_data_out !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL ar_immediate: got vld=%b cnt=%0d ovf=%b data=%0d, expected all 0",
                     m0_valid_out, m0_fifo_count, m0_overflow, m0_data_out);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        q0.delete();
        ready_out = 1'b1;
        send_pixels(0, 32, 1'b1);
        idle(6);
        n_checks++;
        if (q0.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL ar_count: got %0d words, expected 8", q0.size());
        end
        for (int i = 0; i < 8 && i < q0.size(); i++) begin
            n_checks++;
            if (q0[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL ar_word%0d: got %h, expected %h", i, q0[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decimate();
        test_box_average();
        test_overflow();
        test_full_push_pop();
        test_sof_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
